// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front-end.
package uart_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit tick counter, bit counter and 3-sample majority vote around mid-bit.
module uart_rx_sampler #(
    parameter int PRESC_W = 6,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               active,
    input  logic               rx_s,
    input  logic [PRESC_W-1:0] presc,
    output logic               bit_val,
    output logic               smp_done,
    output logic               bit_end,
    output logic [CNT_W-1:0]   bit_cnt
);

    logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESC_W-1:0] half;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               smp_a_q, smp_a_d;
    logic               smp_b_q, smp_b_d;

    assign half    = presc >> 1;
    assign bit_cnt = bit_cnt_q;
    // Third vote is the live input at tick H+1, so the decision is ready that cycle.
    assign bit_val = (smp_a_q & smp_b_q) | (smp_a_q & rx_s) | (smp_b_q & rx_s);

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        smp_a_d    = smp_a_q;
        smp_b_d    = smp_b_q;
        bit_end    = active && (edge_cnt_q == presc - PRESC_W'(1));
        smp_done   = active && (edge_cnt_q == half + PRESC_W'(1));

        // The start-detect cycle is tick 0, so the first counted cycle is tick 1.
        if (start) begin
            edge_cnt_d = PRESC_W'(1);
            bit_cnt_d  = '0;
        end else if (!active) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (bit_end) begin
            edge_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end else begin
            edge_cnt_d = edge_cnt_q + PRESC_W'(1);
        end

        if (active && (edge_cnt_q == half - PRESC_W'(1))) smp_a_d = rx_s;
        if (active && (edge_cnt_q == half))               smp_b_d = rx_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            smp_a_q    <= 1'b1;
            smp_b_q    <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            smp_a_q    <= smp_a_d;
            smp_b_q    <= smp_b_d;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deframer: synchroniser, frame FSM, parity/stop checks and output strobes.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  UART_CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_Data,
    output logic                  RX_Valid,
    output logic                  Par_Err,
    output logic                  Stp_Err
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 4);

    rx_state_e             state_q, state_d;
    logic                  rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  perr_q, perr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, p_data_q, p_data_d;
    logic                  rx_valid_q, rx_valid_d, par_err_q, par_err_d, stp_err_q, stp_err_d;
    logic                  smp_start, active, bit_val, smp_done, bit_end, exp_par;
    logic [CNT_W-1:0]      bit_cnt;

    assign active = (state_q != IDLE);

    uart_rx_sampler #(.PRESC_W(PRESC_W), .CNT_W(CNT_W)) u_sampler (
        .clk      (UART_CLK),
        .rst      (RST),
        .start    (smp_start),
        .active   (active),
        .rx_s     (rx_s_q),
        .presc    (presc_q),
        .bit_val  (bit_val),
        .smp_done (smp_done),
        .bit_end  (bit_end),
        .bit_cnt  (bit_cnt)
    );

    always_comb begin
        rx_meta_d  = RX_IN;
        rx_s_d     = rx_meta_q;
        state_d    = state_q;
        presc_d    = presc_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        perr_d     = perr_q;
        data_d     = data_q;
        p_data_d   = p_data_q;
        rx_valid_d = 1'b0;
        par_err_d  = 1'b0;
        stp_err_d  = 1'b0;
        smp_start  = 1'b0;
        exp_par    = (^data_q) ^ (par_typ_q == PAR_ODD);

        unique case (state_q)
            IDLE: if (!rx_s_q) begin
                state_d   = START;
                smp_start = 1'b1;
                presc_d   = Prescale;
                par_en_d  = PAR_EN;
                par_typ_d = (PAR_TYP == PAR_ODD) ? PAR_ODD : PAR_EVEN;
                perr_d    = 1'b0;
            end
            START: begin
                if (smp_done && bit_val) state_d = IDLE;
                else if (bit_end)        state_d = DATA;
            end
            DATA: begin
                if (smp_done) data_d = {bit_val, data_q[DATA_WIDTH-1:1]};
                if (bit_end && (bit_cnt == CNT_W'(DATA_WIDTH)))
                    state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (smp_done && (bit_val != exp_par)) begin
                    par_err_d = 1'b1;
                    perr_d    = 1'b1;
                end
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                // RX_Valid is a one-cycle strobe with no ready; P_Data holds until the next strobe.
                if (smp_done) begin
                    state_d = IDLE;
                    if (!bit_val) begin
                        stp_err_d = 1'b1;
                    end else if (!perr_q) begin
                        p_data_d   = data_q;
                        rx_valid_d = 1'b1;
                    end
                end else if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge UART_CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            presc_q    <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            perr_q     <= 1'b0;
            data_q     <= '0;
            p_data_q   <= '0;
            rx_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            presc_q    <= presc_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            perr_q     <= perr_d;
            data_q     <= data_d;
            p_data_q   <= p_data_d;
            rx_valid_q <= rx_valid_d;
            par_err_q  <= par_err_d;
            stp_err_q  <= stp_err_d;
        end
    end

    assign P_Data   = p_data_q;
    assign RX_Valid = rx_valid_q;
    assign Par_Err  = par_err_q;
    assign Stp_Err  = stp_err_q;

endmodule
